// File: rtl/uart_rx_frame_parser_if.sv
// Byte-stream bus of the UART frame parser: receiver bytes in, payload
// stream and status pulses out. The statistics counters exist only when
// UART_FRAME_STATS_EN is defined.
interface uart_rx_frame_parser_if;
  logic [7:0]  I_rx_data;
  logic        I_rx_data_valid;
  logic        I_cmd_ready;
  logic [7:0]  o_cmd_data;
  logic        o_cmd_valid;
  logic        o_cmd_last;
  logic        o_frame_ok;
  logic        o_frame_err;
  logic        o_overrun;
  logic        o_busy;
`ifdef UART_FRAME_STATS_EN
  logic [15:0] o_ok_count;
  logic [15:0] o_err_count;
`endif

  // Producer of bytes and consumer of the payload stream.
  modport master (
    output I_rx_data, I_rx_data_valid, I_cmd_ready,
`ifdef UART_FRAME_STATS_EN
    input  o_ok_count, o_err_count,
`endif
    input  o_cmd_data, o_cmd_valid, o_cmd_last,
    input  o_frame_ok, o_frame_err, o_overrun, o_busy
  );

  // The frame parser itself.
  modport slave (
    input  I_rx_data, I_rx_data_valid, I_cmd_ready,
`ifdef UART_FRAME_STATS_EN
    output o_ok_count, o_err_count,
`endif
    output o_cmd_data, o_cmd_valid, o_cmd_last,
    output o_frame_ok, o_frame_err, o_overrun, o_busy
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// UART command frame parser: SOF, LEN, LEN payload bytes, XOR checksum.
// Valid frames are buffered and then streamed out over valid/ready.
// Optional macro UART_FRAME_STATS_EN adds saturating ok/error counters.
//
//  state     | meaning
//  ----------+------------------------------------------------------
//  S_HUNT    | idle, waiting for the SOF byte; other bytes ignored
//  S_LEN     | next byte is the payload length
//  S_PAYLOAD | storing payload bytes and folding them into the XOR
//  S_CHECK   | next byte is compared with the running XOR
//  S_DRAIN   | streaming the buffered payload; new bytes are dropped
module uart_rx_frame_parser #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                   I_sys_clk,
  input  logic                   I_rst,
  uart_rx_frame_parser_if.slave  bus
);

  localparam int PW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN  = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_t;

  state_t        state;
  logic [PW-1:0] len_m1;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic [7:0]    chk;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    pay_mem [0:MAX_PAYLOAD-1];

  logic [7:0]    cmd_data;
  logic          cmd_valid;
  logic          cmd_last;
  logic          frame_ok;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  logic          rx_valid;
  logic [7:0]    rx_data;

  assign rx_valid = bus.I_rx_data_valid;
  assign rx_data  = bus.I_rx_data;
  assign rd_nxt   = rd_ptr + PW'(1);

  // Payload storage needs no reset; only bytes written by the current frame are read.
  always_ff @(posedge I_sys_clk) begin
    if (state == S_PAYLOAD && rx_valid)
      pay_mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  // Frame parsing, timeout supervision and payload streaming.
  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      state     <= S_HUNT;
      len_m1    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      chk       <= '0;
      tmo_cnt   <= '0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      cmd_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        S_HUNT: begin
          tmo_cnt <= '0;
          if (rx_valid && rx_data == SOF_BYTE) begin
            state <= S_LEN;
            busy  <= 1'b1;
          end
        end

        S_LEN, S_PAYLOAD, S_CHECK: begin
          if (!rx_valid) begin
            // An arriving byte always beats expiry, so only idle cycles count.
            if (tmo_cnt == TMO_LAST) begin
              frame_err <= 1'b1;
              state     <= S_HUNT;
              busy      <= 1'b0;
              tmo_cnt   <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end else begin
            tmo_cnt <= '0;
            case (state)
              S_LEN: begin
                if (rx_data == 8'd0 || rx_data > MAX_LEN) begin
                  frame_err <= 1'b1;
                  state     <= S_HUNT;
                  busy      <= 1'b0;
                end else begin
                  len_m1 <= PW'(rx_data - 8'd1);
                  chk    <= rx_data;
                  wr_ptr <= '0;
                  state  <= S_PAYLOAD;
                end
              end
              S_PAYLOAD: begin
                chk    <= chk ^ rx_data;
                wr_ptr <= wr_ptr + PW'(1);
                if (wr_ptr == len_m1)
                  state <= S_CHECK;
              end
              default: begin
                if (rx_data == chk) begin
                  // First payload byte is presented together with the ok pulse.
                  frame_ok  <= 1'b1;
                  rd_ptr    <= '0;
                  cmd_valid <= 1'b1;
                  cmd_data  <= pay_mem[{AW{1'b0}}];
                  cmd_last  <= (len_m1 == '0);
                  state     <= S_DRAIN;
                end else begin
                  frame_err <= 1'b1;
                  state     <= S_HUNT;
                  busy      <= 1'b0;
                end
              end
            endcase
          end
        end

        S_DRAIN: begin
          tmo_cnt <= '0;
          if (rx_valid)
            overrun <= 1'b1;
          if (cmd_valid && bus.I_cmd_ready) begin
            if (cmd_last) begin
              cmd_valid <= 1'b0;
              cmd_last  <= 1'b0;
              state     <= S_HUNT;
              busy      <= 1'b0;
            end else begin
              rd_ptr   <= rd_nxt;
              cmd_data <= pay_mem[rd_nxt[AW-1:0]];
              cmd_last <= (rd_nxt == len_m1);
            end
          end
        end

        default: begin
          state     <= S_HUNT;
          cmd_valid <= 1'b0;
          cmd_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_cmd_data  = cmd_data;
  assign bus.o_cmd_valid = cmd_valid;
  assign bus.o_cmd_last  = cmd_last;
  assign bus.o_frame_ok  = frame_ok;
  assign bus.o_frame_err = frame_err;
  assign bus.o_overrun   = overrun;
  assign bus.o_busy      = busy;

`ifdef UART_FRAME_STATS_EN
  logic [15:0] ok_count;
  logic [15:0] err_count;

  // Saturating tallies of the status pulses, updated the cycle after each pulse.
  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      ok_count  <= '0;
      err_count <= '0;
    end else begin
      if (frame_ok && ok_count != 16'hFFFF)
        ok_count <= ok_count + 16'd1;
      if ((frame_err || overrun) && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

  assign bus.o_ok_count  = ok_count;
  assign bus.o_err_count = err_count;
`endif

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: directed frames plus random
// frames, expected payload and pulses queued from a frame-level model.
module tb_uart_rx_frame_parser;
  localparam int         MAXP = 16;
  localparam int         TMO  = 50;
  localparam logic [7:0] SOF  = 8'hA5;
  localparam int         EV_OK  = 1;
  localparam int         EV_ERR = 2;
  localparam int         EV_OVR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_frame_parser_if bus ();

  uart_rx_frame_parser #(
    .SOF_BYTE       (SOF),
    .MAX_PAYLOAD    (MAXP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .I_sys_clk (clk),
    .I_rst     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_data_q[$];
  int         exp_evt_q[$];
  int         xfer_cyc_q[$];
  logic [7:0] pay[$];
  int         cyc = 0;
  int         xfers = 0;
  int         n_ok_exp = 0;
  int         n_err_exp = 0;
  int         ready_mode = 1;
  logic       pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int         pidx = 0;
  logic       stalled = 1'b0;
  logic [8:0] held = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_evt(input int code);
    if (exp_evt_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse actual=%0d required=none (t=%0t)", code, $time);
    end else begin
      check("pulse_kind", code, exp_evt_q.pop_front());
    end
  endtask

  // Ready driver: random, always-on, fixed stall pattern or held low.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: begin bus.I_cmd_ready = 1'($urandom_range(0, 1)); pidx = 0; end
      1: begin bus.I_cmd_ready = 1'b1; pidx = 0; end
      2: begin
        if (bus.o_cmd_valid && pidx < 6) begin
          bus.I_cmd_ready = pat[pidx];
          pidx++;
        end else begin
          bus.I_cmd_ready = 1'b1;
        end
      end
      default: begin bus.I_cmd_ready = 1'b0; pidx = 0; end
    endcase
  end

  // Monitor: compares pulses and payload transfers against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (bus.o_frame_ok) begin
        expect_evt(EV_OK);
        check("ok_with_valid", bus.o_cmd_valid, 1);
      end
      if (bus.o_frame_err) expect_evt(EV_ERR);
      if (bus.o_overrun)   expect_evt(EV_OVR);
      if (bus.o_cmd_valid) begin
        if (stalled)
          check("stall_hold", {bus.o_cmd_last, bus.o_cmd_data}, held);
        if (bus.I_cmd_ready) begin
          xfers++;
          xfer_cyc_q.push_back(cyc);
          if (exp_data_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer actual=%0h required=none", {bus.o_cmd_last, bus.o_cmd_data});
          end else begin
            check("cmd_byte", {bus.o_cmd_last, bus.o_cmd_data}, exp_data_q.pop_front());
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = {bus.o_cmd_last, bus.o_cmd_data};
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic int gapf(input int mode);
    if (mode == 1) return ($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 2));
    if (mode == 2) return TMO - 1;
    return 0;
  endfunction

  // Entered just after a rising edge; leaves the strobe low just after the edge that sampled it.
  task automatic send_byte(input logic [7:0] b, input int idle);
    bus.I_rx_data_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    bus.I_rx_data       = b;
    bus.I_rx_data_valid = 1'b1;
    @(posedge clk); #1;
    bus.I_rx_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // chk_mode: -1 correct checksum, -2 random wrong checksum, >=0 forced byte.
  task automatic run_frame(input int len, input int chk_mode, input int gap_mode);
    logic [7:0] c;
    logic       good;
    c = 8'(len);
    foreach (pay[i]) c = c ^ pay[i];
    send_byte(SOF, gapf(gap_mode));
    if (len == 0 || len > MAXP) begin
      exp_evt_q.push_back(EV_ERR);
      n_err_exp++;
      send_byte(8'(len), gapf(gap_mode));
      return;
    end
    good = 1'b1;
    if (chk_mode == -2) begin
      c    = c ^ 8'($urandom_range(1, 255));
      good = 1'b0;
    end else if (chk_mode >= 0) begin
      good = (8'(chk_mode) == c);
      c    = 8'(chk_mode);
    end
    send_byte(8'(len), gapf(gap_mode));
    foreach (pay[i]) send_byte(pay[i], gapf(gap_mode));
    if (good) begin
      foreach (pay[i]) exp_data_q.push_back({1'(i == len - 1), pay[i]});
      exp_evt_q.push_back(EV_OK);
      n_ok_exp++;
    end else begin
      exp_evt_q.push_back(EV_ERR);
      n_err_exp++;
    end
    send_byte(c, gapf(gap_mode));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_data_q.size() != 0 || bus.o_cmd_valid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_data_q.size());
    end
    idle(3);
    check("events_pending", exp_evt_q.size(), 0);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1 check("rst_outputs", {bus.o_cmd_valid, bus.o_cmd_last, bus.o_cmd_data, bus.o_frame_ok,
                             bus.o_frame_err, bus.o_overrun, bus.o_busy}, 0);
`ifdef UART_FRAME_STATS_EN
    check("rst_counts", {bus.o_ok_count, bus.o_err_count}, 0);
`endif
    while (exp_data_q.size() != 0) void'(exp_data_q.pop_front());
    while (exp_evt_q.size() != 0) void'(exp_evt_q.pop_front());
    n_ok_exp  = 0;
    n_err_exp = 0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    int x0;
    int len;
    bus.I_rx_data       = 8'h00;
    bus.I_rx_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.o_cmd_valid, bus.o_cmd_last, bus.o_cmd_data, bus.o_frame_ok,
                            bus.o_frame_err, bus.o_overrun, bus.o_busy}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame, ready always high: three back-to-back transfers.
    ready_mode = 1;
    base = xfer_cyc_q.size();
    pay.delete(); pay.push_back(8'h11); pay.push_back(8'h22); pay.push_back(8'h33);
    run_frame(3, -1, 0);
    wait_drain();
    check("t1_xfer_count", xfer_cyc_q.size() - base, 3);
    if (xfer_cyc_q.size() - base == 3)
      check("t1_consecutive", xfer_cyc_q[base + 2] - xfer_cyc_q[base], 2);
    // Checksum 00 does not match LEN^payload (03), so this one is rejected.
    run_frame(3, 8'h00, 0);
    wait_drain();

    // Bad checksum produces no output, then a one-byte frame.
    x0 = xfers;
    run_frame(3, 8'h01, 0);
    wait_drain();
    check("t2_no_output", xfers - x0, 0);
    pay.delete(); pay.push_back(8'h7E);
    run_frame(1, -1, 0);
    wait_drain();

    // Junk in HUNT, then LEN=0 and LEN=MAX+1.
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 1);
    idle(3);
    check("t3_junk_idle", bus.o_busy, 0);
    pay.delete();
    run_frame(0, -1, 0);
    run_frame(MAXP + 1, -1, 0);
    wait_drain();

    // Timeout mid-payload, then a frame with every gap right at expiry.
    send_byte(SOF, 0); send_byte(8'h02, 0); send_byte(8'hAB, 0);
    check("t4_busy_mid", bus.o_busy, 1);
    exp_evt_q.push_back(EV_ERR);
    n_err_exp++;
    idle(TMO);
    check("t4_busy_after_tmo", bus.o_busy, 0);
    idle(2);
    pay.delete(); pay.push_back(8'hAB); pay.push_back(8'hCD);
    run_frame(2, -1, 2);
    wait_drain();

    // Backpressure pattern and overrun during drain.
    ready_mode = 2;
    x0 = xfers;
    pay.delete(); pay.push_back(8'h01); pay.push_back(8'h02); pay.push_back(8'h03);
    run_frame(3, 8'h03, 0);
    wait_drain();
    check("t5_xfers", xfers - x0, 3);
    ready_mode = 3;
    pay.delete(); pay.push_back(SOF); pay.push_back(8'h5A);
    run_frame(2, -1, 0);
    idle(2);
    check("t5_busy_drain", {bus.o_busy, bus.o_cmd_valid}, 2'b11);
    exp_evt_q.push_back(EV_OVR);
    n_err_exp++;
    send_byte(SOF, 0);
    idle(2);
    ready_mode = 0;
    wait_drain();

    // Reset mid-payload and mid-drain, then fresh frames.
    ready_mode = 1;
    send_byte(SOF, 0); send_byte(8'h05, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    do_reset();
    pay.delete(); pay.push_back(8'h10); pay.push_back(8'h20);
    run_frame(2, -1, 0);
    wait_drain();
    ready_mode = 3;
    pay.delete(); pay.push_back(8'h44); pay.push_back(8'h55); pay.push_back(8'h66); pay.push_back(8'h77);
    run_frame(4, -1, 0);
    idle(2);
    check("t6_in_drain", bus.o_cmd_valid, 1);
    do_reset();
    ready_mode = 1;
    pay.delete(); pay.push_back(8'h99);
    run_frame(1, -1, 0);
    wait_drain();

    // Random frames with random gaps, junk and ready.
    ready_mode = 0;
    for (int f = 0; f < 60; f++) begin
      int nj;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == SOF) b = 8'h00;
        send_byte(b, $urandom_range(0, 3));
      end
      pay.delete();
      if ($urandom_range(0, 9) == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAXP + 1, 255));
        run_frame(len, -1, 1);
      end else begin
        len = $urandom_range(1, MAXP);
        for (int i = 0; i < len; i++)
          pay.push_back(($urandom_range(0, 7) == 0) ? SOF : 8'($urandom));
        run_frame(len, ($urandom_range(0, 4) == 0) ? -2 : -1, 1);
      end
      wait_drain();
    end

    idle(3);
    check("final_data_empty", exp_data_q.size(), 0);
`ifdef UART_FRAME_STATS_EN
    check("ok_count", bus.o_ok_count, n_ok_exp);
    check("err_count", bus.o_err_count, n_err_exp);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
